uart_top_tx: RTL and testbench

UART transmitter top level: a programmable baud-tick generator driving a 16x-oversampled serial transmitter. On a start request it sends one 8N1 frame: 1 start bit, 8 data bits LSB first, no parity, 1 stop bit. It sits between a byte-producing host and the serial TX line and reports completion with a one-cycle done pulse.

---
 rtl/uart_top_tx.sv | 155 +++++++++++++++
 tb/tb_uart_top_tx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_top_tx.sv
// UART 8N1 transmitter with a programmable baud-tick generator.
// rst_n keeps its legacy name but is a synchronous, active-high reset.

module uart_baud_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] dvsr,
    output logic        tick_o
);

    logic [10:0] cnt_q;
    logic [10:0] cnt_d;

    // Compare with >= so a shrinking divisor cannot strand the count above it.
    always_comb begin
        tick_o = (cnt_q >= dvsr);
        cnt_d  = tick_o ? 11'd0 : cnt_q + 11'd1;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_q <= 11'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

module uart_top_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_start,
    input  logic [10:0] dvsr,
    input  logic [7:0]  d_in,
    output logic        tx_done,
    output logic        tx_out
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [3:0] S_LAST = 4'(SB_TICK - 1);
    localparam logic [2:0] N_LAST = 3'(DBIT - 1);

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  s_q;
    logic [3:0]  s_d;
    logic [2:0]  n_q;
    logic [2:0]  n_d;
    logic [7:0]  b_q;
    logic [7:0]  b_d;
    logic        tx_q;
    logic        tx_d;
    logic        done_c;
    logic        tick;

    uart_baud_gen u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .dvsr   (dvsr),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        tx_d    = tx_q;
        done_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_start) begin
                    state_d = START;
                    s_d     = 4'd0;
                    b_d     = d_in;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (tick) begin
                    if (s_q == S_LAST) begin
                        state_d = DATA;
                        s_d     = 4'd0;
                        n_d     = 3'd0;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                tx_d = b_q[0];
                if (tick) begin
                    if (s_q == S_LAST) begin
                        s_d = 4'd0;
                        b_d = b_q >> 1;
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (tick) begin
                    if (s_q == S_LAST) begin
                        state_d = IDLE;
                        s_d     = 4'd0;
                        done_c  = 1'b1;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            s_q     <= 4'd0;
            n_q     <= 3'd0;
            b_q     <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
        end
    end

    // A reset landing on the final stop tick must not leak a done pulse.
    assign tx_done = done_c & ~rst_n;
    assign tx_out  = tx_q;

endmodule

// File: tb/tb_uart_top_tx.sv
// Self-checking bench for uart_top_tx: table vectors, random frames
// checked against a bit-timeline model, and multi-cycle corner cases.

module tb_uart_top_tx;

    logic        clk;
    logic        rst_n;
    logic        tx_start;
    logic [10:0] dvsr;
    logic [7:0]  d_in;
    logic        tx_done;
    logic        tx_out;

    int total;
    int bad;

    typedef struct {
        logic [7:0]  din;
        logic [10:0] dv;
        logic [9:0]  bits;
        int          per;
    } vec_t;

    vec_t tbl[3];

    uart_top_tx dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_start (tx_start),
        .dvsr     (dvsr),
        .d_in     (d_in),
        .tx_done  (tx_done),
        .tx_out   (tx_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, exp);
        end
    endtask

    // Frame on the line: start(0), byte LSB first, stop(1).
    function automatic logic [9:0] mk_bits(input logic [7:0] v);
        return {1'b1, v, 1'b0};
    endfunction

    // Line must stay idle-high with no done pulse for n clks.
    task automatic idle_chk(input string nm, input int n);
        int errs;
        errs = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx_out !== 1'b1 || tx_done !== 1'b0) errs++;
        end
        chk(nm, errs, 0);
    endtask

    // Called with tx_start already high before the acceptance edge.
    // Sample 0 is the first negedge after acceptance.
    task automatic check_frame(input string nm, input logic [9:0] bits,
                               input int per, input bit keep, input int dis);
        logic q[$];
        int   d;
        int   j;
        int   bnd;
        int   b;
        int   L;
        int   bi;
        int   mis;
        logic e;
        logic dn1;
        d   = -1;
        j   = 0;
        bnd = 11 * per + 50;
        b   = per / 16;
        while (d < 0 && j < bnd) begin
            @(negedge clk);
            if (j == 0 && !keep) tx_start = 1'b0;
            if (dis >= 0 && j == dis) begin
                d_in     = ~d_in;
                tx_start = 1'b1;
            end
            if (dis >= 0 && j == dis + 1) tx_start = 1'b0;
            q.push_back(tx_out);
            if (tx_done === 1'b1) d = j;
            j++;
        end
        total++;
        if (d < 0) begin
            bad++;
            $display("FAIL %s timeout: no tx_done within %0d clks", nm, bnd);
            tx_start = 1'b0;
            return;
        end
        @(negedge clk);
        q.push_back(tx_out);
        dn1 = tx_done;
        chk({nm, "_lat"}, int'({q[0], q[1]}), 2);
        L = d + 1 - 9 * per;
        total++;
        if (L < 15 * b + 1 || L > 16 * b) begin
            bad++;
            $display("FAIL %s_startlen: got %0d want %0d..%0d",
                     nm, L, 15 * b + 1, 16 * b);
        end
        mis = 0;
        for (int idx = 1; idx <= d + 1; idx++) begin
            if (idx <= L) begin
                e = 1'b0;
            end else begin
                bi = 1 + (idx - L - 1) / per;
                if (bi > 9) bi = 9;
                e = bits[bi];
            end
            if (q[idx] !== e) mis++;
        end
        chk({nm, "_wave"}, mis, 0);
        chk({nm, "_donew"}, int'(dn1), 0);
    endtask

    initial begin
        int h;
        logic [7:0]  rb;
        logic [10:0] rd;
        total    = 0;
        bad      = 0;
        rst_n    = 1'b1;
        tx_start = 1'b1;
        d_in     = 8'h5A;
        dvsr     = 11'd2;

        tbl[0] = '{din: 8'hAA, dv: 11'd2, bits: 10'b1_10101010_0, per: 48};
        tbl[1] = '{din: 8'h01, dv: 11'd0, bits: 10'b1_00000001_0, per: 16};
        tbl[2] = '{din: 8'h55, dv: 11'd1, bits: 10'b1_01010101_0, per: 32};

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_tx", int'(tx_out), 1);
            chk("rst_done", int'(tx_done), 0);
        end
        tx_start = 1'b0;
        rst_n    = 1'b0;
        idle_chk("rst_nostart", 5);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dvsr     = tbl[i].dv;
            d_in     = tbl[i].din;
            tx_start = 1'b1;
            check_frame($sformatf("tbl%0d", i), tbl[i].bits, tbl[i].per, 1'b0, -1);
            idle_chk($sformatf("tbl%0d_idle", i), 4);
        end

        @(negedge clk);
        dvsr     = 11'd2;
        d_in     = 8'h55;
        tx_start = 1'b1;
        check_frame("held1", mk_bits(8'h55), 48, 1'b1, -1);
        check_frame("held2", mk_bits(8'h55), 48, 1'b0, -1);
        idle_chk("held_idle", 4);

        @(negedge clk);
        dvsr     = 11'd1;
        d_in     = 8'hC3;
        tx_start = 1'b1;
        check_frame("midev", mk_bits(8'hC3), 32, 1'b0, 128);
        idle_chk("midev_noextra", 40);

        @(negedge clk);
        dvsr     = 11'd2;
        d_in     = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (150) @(negedge clk);
        chk("prerst_data", int'(tx_out), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_tx", int'(tx_out), 1);
        chk("midrst_done", int'(tx_done), 0);
        rst_n = 1'b0;
        idle_chk("midrst_quiet", 600);

        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom);
            rd = 11'($urandom_range(0, 3));
            @(negedge clk);
            dvsr     = rd;
            d_in     = rb;
            tx_start = 1'b1;
            check_frame($sformatf("rnd%0d_%02h", i, rb), mk_bits(rb),
                        16 * (int'(rd) + 1), 1'b0, -1);
        end

        @(negedge clk);
        dvsr     = 11'd2047;
        d_in     = 8'h01;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        for (int i = 0; i < 10 && tx_out === 1'b1; i++) @(negedge clk);
        for (int i = 0; i < 33000 && tx_out === 1'b0; i++) @(negedge clk);
        h = 1;
        for (int i = 0; i < 33000; i++) begin
            @(negedge clk);
            if (tx_out !== 1'b1) break;
            h++;
        end
        chk("bigdiv_period", h, 32768);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
